// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : State, opcode and datapath-select encodings for the multi-cycle
//            RV32I control FSM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ctrl_next_state.sv
// ============================================================================
// Module   : ctrl_next_state
// Brief    : Pure combinational next-state logic of the control FSM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_next_state
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output state_t     next_state
);

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  next_state = MEMADR;
                    OP_RTYPE:  next_state = EXECUTER;
                    OP_ITYPE:  next_state = EXECUTEI;
                    OP_JAL:    next_state = JAL;
                    OP_BRANCH: next_state = BEQ;
                    default:   next_state = ILLEGAL;
                endcase
            end
            MEMADR:   next_state = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            JAL:      next_state = ALUWB;
            BEQ:      next_state = FETCH;
            // ILLEGAL is a trap: only reset leaves it
            ILLEGAL:  next_state = ILLEGAL;
            default:  next_state = FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_ctrl_fsm.sv
// ============================================================================
// Module   : multi_cycle_ctrl_fsm
// Brief    : Main control FSM of the multi-cycle RV32I core: flop enables,
//            memory strobes and datapath mux selects per instruction phase.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_cycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next_state;
    logic   w_pc_update;
    logic   w_branch;

    ctrl_next_state u_next_state (
        .state      (r_state),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state_o = r_state;

    // Outputs are forced low while reset is high so an interrupted
    // instruction cannot write back or store during the reset cycle.
    always_comb begin
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALURESULT;
                    ir_write    = mem_ready;
                    w_pc_update = mem_ready;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                MEMREAD: begin
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src = RES_READDATA;
                    reg_write  = 1'b1;
                end
                MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                EXECUTER: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                end
                EXECUTEI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                end
                JAL: begin
                    alu_src_a   = SRCA_OLDPC;
                    alu_src_b   = SRCB_FOUR;
                    w_pc_update = 1'b1;
                end
                BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    w_branch  = 1'b1;
                end
                ILLEGAL: begin
                    illegal_instr = 1'b1;
                end
                default: begin
                end
            endcase
        end
        pc_write = w_pc_update | (w_branch & zero);
    end

endmodule

`default_nettype wire

// File: doc/multi_cycle_ctrl_fsm.md
# multi_cycle_ctrl_fsm

Main control state machine of the multi-cycle RV32I core; it produces the write enables consumed by the core's enable-flops (CurrPC, OldPC, Instr) and the register file, plus all datapath mux selects. It sequences each instruction through fetch, decode, execute, memory and writeback states, stalling on a memory ready handshake. It sits beside the datapath and reads the opcode from the Instr register output and the ALU zero flag.

## Interface
- No parameters (encodings fixed in package).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- opcode  in  7  Instr[6:0] from the Instr register.
- zero  in  1  ALU zero flag, combinational from the datapath.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  CurrPC flop enable; pc_update | (branch & zero).
- ir_write  out  1  Instr and OldPC flop enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 ALUOut, 01 ReadData, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 (A register).
- alu_src_b  out  2  00 rs2 (WriteData), 01 ImmExt, 10 constant 4.
- alu_op  out  2  00 add, 01 subtract (branch), 10 decode funct3/funct7.
- illegal_instr  out  1  sticky; unsupported opcode decoded.
- state_o  out  4  current state, for debug.

## Operation
- Outputs default to 0 in every state unless listed; reset forces state FETCH and all outputs to 0 in that cycle.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready (Mealy). Stay until mem_ready=1, then DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; other -> ILLEGAL.
- MEMADR: a=10, b=01, alu_op=00. Next: opcode 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Stay until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 held every cycle until mem_ready=1 -> FETCH.
- EXECUTER: a=10, b=00, alu_op=10 -> ALUWB.
- EXECUTEI: a=10, b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB (rd <= OldPC+4).
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1 -> FETCH; pc_write=zero.
- ILLEGAL: all enables 0, illegal_instr=1; exits only via reset.
- ir_write and mem_write never asserted in the same cycle; reg_write only in MEMWB/ALUWB.

## Timing
- State register updates on rising clk; outputs combinational from state (and mem_ready/zero where noted).
- Instruction latency with mem_ready always 1: BEQ 3 cycles, R/I-type 4, JAL 4, SW 4, LW 5; each wait cycle on mem_ready adds one.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- reset asserted mid-instruction: next cycle state=FETCH, no partial writeback or memory write occurs after the reset edge.
- opcode is only sampled in DECODE and MEMADR; it is stable there because ir_write is 0 outside FETCH.

## Structure
- Package ctrl_pkg: 4-bit state enum (FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, ILLEGAL), opcode constants, result_src/alu_src_a/alu_src_b/alu_op encodings.
- One sub-module natural: ctrl_next_state (pure combinational next-state from state, opcode, mem_ready); output decode stays in the top.

## Test plan
- Reset held 2 cycles mid-EXECUTER -> state_o=0 (FETCH), all enables 0 during reset; after release with mem_ready=1, ir_write=pc_write=1 in first cycle.
- LW (opcode 0000011), mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> states FETCH x3, DECODE, MEMADR, MEMREAD x4, MEMWB; reg_write=1 only in MEMWB with result_src=01.
- SW (0100011), mem_ready low 1 cycle in MEMWRITE -> mem_write=1 for exactly 2 cycles with adr_src=1, then FETCH; reg_write never 1.
- BEQ (1100011) with zero=1 then zero=0 -> pc_write=1 in BEQ cycle first time, 0 second time; both return to FETCH after 3 cycles.
- JAL (1101111) -> pc_write=1 in JAL state with a=01, b=10; next ALUWB reg_write=1, result_src=00.
- Opcode 1110011 -> ILLEGAL after DECODE, illegal_instr=1 held for 20 cycles despite mem_ready toggling; cleared only by reset.
